// File: rtl/cpe_column_scheduler.sv
// cpe_column_scheduler
// Sequences one column of compensation PEs. A tile has three phases:
//   1. Weight load: ROWS reads from compensation memory, issued highest index
//      first and one at a time, each returned weight shifted into the chain.
//   2. Compute: a stream of num_vec activation vectors is gated into the column.
//   3. Drain: ROWS+1 cycles for the last partial sum to leave the tail CPE.
// The load and compute phases never overlap, because a CPE holds its
// compensation output while its weight-valid is high.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   start, num_vec           tile request; num_vec is sampled with start in IDLE
//   cw_rd_en, cw_rd_idx      one-cycle read request to compensation memory
//   cw_rd_valid, cw_rd_data  read response; any latency of at least one cycle
//   cw_out, cw_out_valid     weight and shift strobe into the head CPE
//   act_valid_in, act_ready  activation handshake with upstream
//   act_cout_valid           MAC enable to every CPE; one cycle after acceptance
//   busy, done               status; done is a one-cycle pulse ending the tile
module cpe_column_scheduler #(
    parameter int ROWS  = 8,
    parameter int CNT_W = 8,
    parameter int IDX_W = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    output logic             cw_rd_en,
    output logic [IDX_W-1:0] cw_rd_idx,
    input  logic             cw_rd_valid,
    input  logic [3:0]       cw_rd_data,
    output logic [3:0]       cw_out,
    output logic             cw_out_valid,
    input  logic             act_valid_in,
    output logic             act_ready,
    output logic             act_cout_valid,
    output logic             busy,
    output logic             done
);

    // The drain counter must be able to hold the value ROWS.
    localparam int DR_W = $clog2(ROWS + 1);

    typedef enum logic [2:0] {
        IDLE, LOAD_REQ, LOAD_WAIT, COMPUTE, DRAIN, DONE
    } state_t;

    state_t            state, state_n;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  vec_left;
    logic [DR_W-1:0]   drain_cnt;
    logic              wt_fire;
    logic              act_fire;

    // Read data is accepted only while a read is outstanding. A response that
    // arrives in any other state is dropped.
    assign wt_fire  = (state == LOAD_WAIT) && cw_rd_valid;
    assign act_fire = (state == COMPUTE) && act_valid_in;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (start) state_n = LOAD_REQ;
            LOAD_REQ:  state_n = LOAD_WAIT;
            LOAD_WAIT: if (cw_rd_valid) begin
                           if (idx != '0)            state_n = LOAD_REQ;
                           else if (vec_left == '0)  state_n = DRAIN;
                           else                      state_n = COMPUTE;
                       end
            COMPUTE:   if (act_fire && vec_left == CNT_W'(1)) state_n = DRAIN;
            DRAIN:     if (drain_cnt == DR_W'(ROWS)) state_n = DONE;
            DONE:      state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= '0;
            vec_left       <= '0;
            drain_cnt      <= '0;
            cw_out         <= '0;
            cw_out_valid   <= 1'b0;
            act_cout_valid <= 1'b0;
        end else begin
            state          <= state_n;
            cw_out_valid   <= wt_fire;
            act_cout_valid <= act_fire;
            if (wt_fire) cw_out <= cw_rd_data;

            case (state)
                IDLE: if (start) begin
                    vec_left <= num_vec;
                    idx      <= IDX_W'(ROWS - 1);
                end
                LOAD_WAIT: if (cw_rd_valid && idx != '0) idx <= idx - 1'b1;
                COMPUTE:   if (act_fire) vec_left <= vec_left - 1'b1;
                default: ;
            endcase

            // Counts 0..ROWS inside DRAIN, which gives ROWS+1 drain cycles.
            drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
        end
    end

    assign cw_rd_en  = (state == LOAD_REQ);
    assign cw_rd_idx = cw_rd_en ? idx : '0;
    assign act_ready = (state == COMPUTE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_cpe_column_scheduler.sv
module tb_cpe_column_scheduler;

    localparam int ROWS = 4;
    localparam int EV_W = 1, EV_A = 2, EV_D = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] num_vec;
    logic       cw_rd_en;
    logic [1:0] cw_rd_idx;
    logic       cw_rd_valid;
    logic [3:0] cw_rd_data;
    logic [3:0] cw_out;
    logic       cw_out_valid;
    logic       act_valid_in;
    logic       act_ready;
    logic       act_cout_valid;
    logic       busy;
    logic       done;

    cpe_column_scheduler #(.ROWS(ROWS), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
        .cw_rd_en(cw_rd_en), .cw_rd_idx(cw_rd_idx),
        .cw_rd_valid(cw_rd_valid), .cw_rd_data(cw_rd_data),
        .cw_out(cw_out), .cw_out_valid(cw_out_valid),
        .act_valid_in(act_valid_in), .act_ready(act_ready),
        .act_cout_valid(act_cout_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int kind; int val; int cyc; } ev_t;
    ev_t q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    // Stimulus knobs shared with the responder processes.
    int mem_lat  = 1;
    bit spur     = 1'b0;
    bit act_tog  = 1'b0;
    int act_base = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic pop_cmp(input int kind, input int val);
        ev_t e;
        if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event @cycle %0d: got kind %0d, expected none", cyc, kind);
        end else begin
            e = q.pop_front();
            chk("ev_kind", kind, e.kind);
            chk("ev_value", val, e.val);
            chk("ev_cycle", cyc, e.cyc);
        end
    endtask

    // Monitor: compares every strobe the DUT presents against the scoreboard.
    initial forever begin
        @(negedge clk);
        if (cw_out_valid || act_cout_valid)
            chk("no_overlap", int'(cw_out_valid && act_cout_valid), 0);
        if (cw_out_valid)   pop_cmp(EV_W, int'(cw_out));
        if (act_cout_valid) pop_cmp(EV_A, 0);
        if (done)           pop_cmp(EV_D, 0);
    end

    // Compensation memory: data[idx] = idx+1, fixed latency mem_lat, plus an
    // injectable spurious valid carrying 4'hF.
    initial begin
        bit       pend = 1'b0;
        int       cnt  = 0;
        logic [3:0] dat = '0;
        bit       mv;
        cw_rd_valid = 1'b0;
        cw_rd_data  = '0;
        forever begin
            @(posedge clk);
            #2;
            mv = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    mv   = 1'b1;
                    pend = 1'b0;
                end
            end
            cw_rd_valid = mv || spur;
            cw_rd_data  = mv ? dat : (spur ? 4'hF : 4'h0);
            if (cw_rd_en) begin
                pend = 1'b1;
                cnt  = mem_lat;
                dat  = 4'(cw_rd_idx) + 4'd1;
            end
        end
    end

    // Activation source: held high, or 1,0,1,0,... starting at act_base.
    initial begin
        act_valid_in = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            act_valid_in = act_tog ? (cyc >= act_base && ((cyc - act_base) % 2 == 0)) : 1'b1;
        end
    end

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issues start in the current cycle s and queues the expected strobes:
    // weight k appears at s+(k+1)(lat+1)+1 with value ROWS-k, compute opens at
    // C=s+ROWS(lat+1)+1, and done follows ROWS+1 drain cycles.
    task automatic start_tile(input int n, input int lat, input bit tog,
                              output int s, output int d);
        int c0, last;
        s       = cyc;
        mem_lat = lat;
        c0      = s + ROWS * (lat + 1) + 1;
        for (int k = 0; k < ROWS; k++)
            q.push_back('{EV_W, ROWS - k, s + (k + 1) * (lat + 1) + 1});
        act_tog  = tog;
        act_base = c0;
        last     = c0 - 1;
        for (int i = 0; i < n; i++) begin
            last = tog ? c0 + 2 * i : c0 + i;
            q.push_back('{EV_A, 0, last + 1});
        end
        d = last + 1 + (ROWS + 1);
        q.push_back('{EV_D, 0, d});
        start   = 1'b1;
        num_vec = 8'(n);
        @(posedge clk);
        #1;
        start   = 1'b0;
        num_vec = '0;
    endtask

    initial begin
        int s, d, seen;
        rst     = 1'b1;
        start   = 1'b0;
        num_vec = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cw_rd_en", int'(cw_rd_en), 0);
        chk("rst_cw_rd_idx", int'(cw_rd_idx), 0);
        chk("rst_cw_out", int'(cw_out), 0);
        chk("rst_cw_out_valid", int'(cw_out_valid), 0);
        chk("rst_act_ready", int'(act_ready), 0);
        chk("rst_act_cout_valid", int'(act_cout_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst = 1'b0;

        // Spurious read data while idle must not strobe the chain.
        goto(cyc + 1);
        spur = 1'b1;
        goto(cyc + 1);
        spur = 1'b0;
        goto(cyc + 3);

        // Basic tile: latency 1, three vectors, activations held high.
        start_tile(3, 1, 1'b0, s, d);
        chk("t1_busy_after_start", int'(busy), 1);
        chk("t1_first_rd_en", int'(cw_rd_en), 1);
        chk("t1_first_rd_idx", int'(cw_rd_idx), ROWS - 1);
        goto(d);
        chk("t1_busy_at_done", int'(busy), 1);
        goto(d + 1);
        chk("t1_idle_after_done", int'(busy), 0);

        // Latency 3 with a toggling activation source.
        start_tile(3, 3, 1'b1, s, d);
        goto(d + 1);
        act_tog = 1'b0;

        // Empty tile: full load, drain, done, never ready.
        start_tile(0, 1, 1'b0, s, d);
        seen = 0;
        while (cyc < d + 1) begin
            if (act_ready) seen = 1;
            @(posedge clk);
            #1;
        end
        chk("nv0_no_act_ready", seen, 0);

        // Spurious valid and a stray start during compute change nothing.
        start_tile(3, 1, 1'b0, s, d);
        goto(s + 9);
        spur = 1'b1;
        goto(s + 10);
        spur    = 1'b0;
        start   = 1'b1;
        num_vec = 8'd7;
        goto(s + 11);
        start   = 1'b0;
        num_vec = '0;
        goto(d + 1);
        chk("stray_start_idle", int'(busy), 0);

        // Reset while a read is outstanding; the late response is dropped.
        mem_lat = 3;
        s       = cyc;
        start   = 1'b1;
        num_vec = 8'd3;
        goto(s + 1);
        start   = 1'b0;
        num_vec = '0;
        goto(s + 2);
        rst = 1'b1;
        goto(s + 3);
        rst = 1'b0;
        chk("abort_outputs_zero",
            int'({cw_rd_en, cw_rd_idx, cw_out, cw_out_valid, act_ready,
                  act_cout_valid, busy, done}), 0);
        goto(s + 5);
        chk("abort_no_strobe", int'(cw_out_valid), 0);
        chk("abort_idle", int'(busy), 0);
        goto(s + 7);
        start_tile(3, 1, 1'b0, s, d);
        goto(d + 1);

        // Back-to-back tiles; the second one is long enough to exercise the
        // full range of the vector counter.
        start_tile(2, 1, 1'b0, s, d);
        goto(d + 1);
        start_tile(255, 1, 1'b0, s, d);
        goto(d + 2);
        chk("queue_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpe_column_scheduler.md
# cpe_column_scheduler

Sequencer for one column of compensation processing elements (CPEs) in the systolic array. It fetches ROWS 4-bit compensation weights from compensation memory and shifts them into the CPE weight chain. It then gates a stream of activation vectors into the column and waits out the partial-sum skew before signalling completion. Weight loading and activation streaming never overlap, because a CPE holds its compensation output while its weight-valid is high.

## Interface
- ROWS, 8, number of CPEs chained in the column (≥2)
- CNT_W, 8, width of the vector counter and num_vec
- IDX_W, $clog2(ROWS), width of cw_rd_idx

- clk  in  1  clock, all logic on posedge
- rst  in  1  reset, synchronous, active-high; dominates every other input
- start  in  1  one-cycle request to run a tile; sampled only in IDLE
- num_vec  in  CNT_W  number of activation vectors in the tile; sampled with start
- cw_rd_en  out  1  one-cycle read request to compensation memory
- cw_rd_idx  out  IDX_W  weight index of the current read
- cw_rd_valid  in  1  read data valid; any latency ≥1 cycle after cw_rd_en
- cw_rd_data  in  4  compensation weight
- cw_out  out  4  weight presented to the head CPE
- cw_out_valid  out  1  weight shift strobe; drives every CPE's weight-out-valid
- act_valid_in  in  1  upstream activation vector available
- act_ready  out  1  scheduler accepts an activation vector this cycle
- act_cout_valid  out  1  drives every CPE's activation-valid (MAC enable)
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at tile completion

## Operation
- States: IDLE, LOAD_REQ, LOAD_WAIT, COMPUTE, DRAIN, DONE.
- **IDLE**
  - start=1: latch num_vec into vec_left, set idx=ROWS-1, go to LOAD_REQ.
- **LOAD_REQ**
  - cw_rd_en=1 and cw_rd_idx=idx for exactly one cycle, then go to LOAD_WAIT.
  - Only one read is outstanding at a time.
- **LOAD_WAIT**
  - On cw_rd_valid: register cw_out=cw_rd_data and pulse cw_out_valid=1 for one cycle.
  - If idx==0, go to COMPUTE (or DRAIN if vec_left==0). Otherwise decrement idx and go to LOAD_REQ.
  - Index ROWS-1 is loaded first, so after ROWS strobes CPE k holds weight k (CPE 0 is the head).
- **COMPUTE**
  - act_ready=1.
  - On each act_valid_in&&act_ready: decrement vec_left, and act_cout_valid=1 in the following cycle (registered).
  - When the last vector is accepted (vec_left==1), go to DRAIN.
- **DRAIN**
  - act_ready=0.
  - Count ROWS+1 cycles, long enough for the last partial sum to leave the tail CPE, then go to DONE.
- **DONE**
  - done=1 for one cycle, then go to IDLE.
- cw_out_valid and act_cout_valid are never high in the same cycle.
- cw_out holds its last value when cw_out_valid=0.
- start outside IDLE is ignored.
- cw_rd_valid outside LOAD_WAIT is ignored and does not strobe the chain.
- num_vec=0: the full weight load still runs, then DRAIN, then DONE. No act_ready is ever raised.

## Timing
- Reset values: cw_rd_en=0, cw_rd_idx=0, cw_out=0, cw_out_valid=0, act_ready=0, act_cout_valid=0, busy=0, done=0. State returns to IDLE and counters clear.
- rst asserted mid-tile (any state) aborts the tile in the same edge. No done pulse is produced, and a later cw_rd_valid is dropped.
- start at edge t: busy=1 and state=LOAD_REQ from t+1, cw_rd_en=1 at t+1.
- cw_rd_valid in cycle c (during LOAD_WAIT): cw_out_valid=1 in cycle c+1. For that same edge:
  - the next cw_rd_en is in cycle c+1 if more weights remain;
  - otherwise act_ready=1 from c+1.
- Load phase with memory latency L: ROWS·(L+1) cycles.
- Accepted vector in cycle a: act_cout_valid=1 in cycle a+1.
- DRAIN spans ROWS+1 cycles, done is in the cycle after DRAIN, and busy falls with done's falling edge (busy=1 during done).
- start in the cycle after done is accepted, so back-to-back tiles are allowed.

## Test plan
- ROWS=4, memory latency 1, data[idx]=idx+1, start with num_vec=3, act_valid_in held high -> 4 strobes with cw_out=4,3,2,1, then act_cout_valid high 3 consecutive cycles, 5 drain cycles, then one done pulse; busy high throughout.
- Memory latency 3 with act_valid_in toggling 1,0,1,0,1 -> exactly 3 acceptances, act_cout_valid follows each by 1 cycle, and cw_out_valid and act_cout_valid never overlap.
- num_vec=0 -> 4 weight strobes, act_ready never high, done after the 5 drain cycles.
- Spurious cw_rd_valid in IDLE and in COMPUTE, plus start asserted during COMPUTE -> no cw_out_valid, no state change, and tile timing unchanged.
- rst raised in LOAD_WAIT while a read is outstanding, then the memory returns valid -> all outputs 0 and no strobe; a fresh start then runs a full tile correctly.
- start asserted in the cycle immediately after done, with num_vec=255 -> second tile runs, accepts 255 vectors, and the counter does not wrap early.
